// File: rtl/mux8_arb_pkg.sv
// mux8_arb_pkg: shared state enum and widths for the round-robin mux arbiter
package mux8_arb_pkg;
    localparam int NREQ  = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/mux8_rr_pick.sv
// mux8_rr_pick: first set bit of mask searching upward from ptr with wrap 7->0
module mux8_rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [NREQ-1:0]  mask,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             vld
);
    // scan from the far end back toward ptr so the nearest candidate wins
    always_comb begin
        idx = ptr;
        vld = |mask;
        for (int i = NREQ - 1; i >= 0; i--)
            if (mask[ptr + SEL_W'(i)]) idx = ptr + SEL_W'(i);
    end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin 8-to-1 mux arbiter with bounded tenure; MUX8_ARB_LOCK_EN enables burst lock
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  d,
    input  logic [NREQ-1:0]  lock,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             y,
    output logic             y_vld
);
    state_t             state, state_n;
    logic [SEL_W-1:0]   ptr, ptr_n, owner, owner_n, pick;
    logic [CNT_W-1:0]   hold_cnt, hold_n;
    logic [NREQ-1:0]    gnt_n, others;
    logic               pick_vld, locked, hold_max, take, drop;

    // gnt is zero in IDLE, so this mask serves both the initial pick and re-picks
    assign others   = req & ~gnt;
    assign hold_max = hold_cnt == CNT_W'(MAX_HOLD);
    assign busy     = state == GRANT;
    assign sel      = owner;

`ifdef MUX8_ARB_LOCK_EN
    assign locked = lock[owner];
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign locked      = 1'b0;
`endif

    mux8_rr_pick u_pick (
        .mask (others),
        .ptr  (ptr),
        .idx  (pick),
        .vld  (pick_vld)
    );

    // next grant: new pick on idle entry, owner drop, or unlocked forced rotation
    always_comb begin
        take    = pick_vld && (state == IDLE || !req[owner] || (hold_max && !locked));
        drop    = state == GRANT && !req[owner] && !pick_vld;
        state_n = take ? GRANT : drop ? IDLE : state;
        gnt_n   = take ? NREQ'(1) << pick : drop ? '0 : gnt;
        owner_n = take ? pick : owner;
        ptr_n   = take ? pick + SEL_W'(1) : ptr;
        hold_n  = take ? CNT_W'(1) : (state == GRANT && !hold_max) ? hold_cnt + CNT_W'(1) : hold_cnt;
    end

    // state, arbitration registers and the registered mux output
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            y        <= 1'b0;
            y_vld    <= 1'b0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            y        <= busy ? d[sel] : 1'b0;
            y_vld    <= busy;
        end
    end
endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer for the shared 8-to-1 single-bit mux datapath. It shares one output line between eight requesters. It grants one requester at a time, drives the registered 3-bit select, and registers the selected data bit. Grant tenure is bounded by a hold counter so that no requester starves.

## Interface
Parameters:
- MAX_HOLD, 4: maximum consecutive grant cycles before a forced rotation when others are waiting. Legal range 1..15.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- req, in, 8: request per requester. Held high for the whole transfer.
- d, in, 8: data bit per requester, the mux inputs D0..D7.
- lock, in, 8: per-requester burst lock. Used only with MUX8_ARB_LOCK_EN; ignored otherwise.
- gnt, out, 8: one-hot grant, registered.
- sel, out, 3: registered select, equal to the index of the granted requester.
- busy, out, 1: high while in GRANT.
- y, out, 1: registered mux output.
- y_vld, out, 1: y carries the owner's data.

## Operation
- Two-state FSM: IDLE and GRANT.
- Internal registers:
  - ptr (3 bits): search start.
  - owner (3 bits).
  - hold_cnt (4 bits).
- Pick function: the first set bit of the candidate mask, searching from ptr upward with wrap 7→0.
- IDLE:
  - If req != 0: pick from req, enter GRANT.
  - On entry: gnt = one-hot(pick), sel = pick, hold_cnt = 1, ptr = pick+1 (mod 8).
- GRANT, evaluated every cycle with others = req & ~gnt:
  - req[owner]=0, others=0: go to IDLE, clear gnt.
  - req[owner]=0, others≠0: re-pick from others. The new grant is active the next cycle, with no idle gap.
  - req[owner]=1, hold_cnt==MAX_HOLD, others≠0: forced release. Re-pick from others.
  - req[owner]=1, otherwise: stay. hold_cnt increments, saturating at MAX_HOLD.
- Every new grant sets hold_cnt=1 and ptr=pick+1.
- Datapath: each cycle y <= d[sel] and y_vld <= busy. When not busy, y is 0.
- Requests asserted while an owner holds the grant wait. They are never granted mid-tenure.
- Reset values: gnt=0, sel=0, busy=0, y=0, y_vld=0, ptr=0, owner=0, hold_cnt=0, state IDLE.

## Timing
- req rising at edge t (IDLE): gnt, sel and busy are valid after edge t+1. y and y_vld are valid after edge t+2.
- Owner drop sampled at edge t: the new gnt is valid after t+1. y_vld stays 1 continuously across a back-to-back handover.
- Forced rotation: the owner holds gnt for exactly MAX_HOLD cycles. The next owner's gnt appears the cycle after.
- With MAX_HOLD=1 and all req high, the grant rotates every cycle: 0,1,2,…,7,0.
- rst mid-transfer: all outputs reach their reset values after the next edge, regardless of req. The first grant after reset uses ptr=0.
- gnt is always zero or one-hot. sel changes only on a new grant.

## Configuration
- MUX8_ARB_LOCK_EN defined: when lock[owner]=1, the forced release at MAX_HOLD is suppressed. The owner keeps the grant until req[owner] drops. hold_cnt stays saturated meanwhile.
- MUX8_ARB_LOCK_EN undefined: the lock port is unused, and forced rotation always applies.

## Structure
- The shared package mux8_arb_pkg holds:
  - The state enum (IDLE, GRANT).
  - NREQ=8.
  - SEL_W=3.
  - CNT_W=4.
- The sub-module mux8_rr_pick is combinational. It takes an 8-bit mask and a 3-bit ptr and returns a 3-bit index and a valid flag. It is instantiated once and used for both IDLE and GRANT re-picks.
- The top level contains the FSM, counters and output registers.

## Test plan
- Reset then req=8'h04, d=8'h04 → gnt=8'h04 and sel=2 after 1 cycle. y=1 and y_vld=1 after 2 cycles.
- MAX_HOLD=4, req=8'h81 held → owner 0 for 4 cycles, then owner 7 for 4 cycles, then owner 0. Each grant is exactly 4 cycles.
- Owner 3 drops req while req[5]=1 → gnt moves 8'h08→8'h20 with no busy gap, and y_vld stays 1.
- rst asserted during GRANT with req=8'hFF → next cycle gnt=0, sel=0, y_vld=0. After rst drops, the first grant is requester 0.
- MAX_HOLD=1, req=8'hFF → sel sequence 0,1,…,7,0 on consecutive cycles.
- MUX8_ARB_LOCK_EN defined, lock[2]=1, req=8'h06, owner 2 → owner 2 holds for 10 cycles, past MAX_HOLD. When req[2] drops, the grant goes to 1. Without the macro, the same stimulus rotates to 1 after 4 cycles.
